// File: rtl/fwd_scoreboard_if.sv
// EX-side bundle for the forwarding/load-use unit: pipeline control, EX operand
// selects and the per-port forward selects, stall and stall counter going back.
interface fwd_scoreboard_if #(
    parameter int DEPTH = 2,
    parameter int NRD   = 2,
    parameter int AW    = 5,
    parameter int CNTW  = 32
);
    localparam int SW = $clog2(DEPTH + 1);

    logic                     advance;
    logic                     flush;
    logic                     ex_wen;
    logic [AW-1:0]            ex_wsel;
    logic                     ex_load;
    logic [NRD-1:0][AW-1:0]   rsel;
    logic [NRD-1:0]           ruse;
    logic                     mem_ready;
    logic [NRD-1:0][SW-1:0]   fwd_sel;
    logic                     stall;
    logic [CNTW-1:0]          stall_count;

    modport master (
        output advance, flush, ex_wen, ex_wsel, ex_load, rsel, ruse, mem_ready,
        input  fwd_sel, stall, stall_count
    );

    modport slave (
        input  advance, flush, ex_wen, ex_wsel, ex_load, rsel, ruse, mem_ready,
        output fwd_sel, stall, stall_count
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: a shift register of in-flight producers
// past EX, youngest-match forward select per read port, load-use stall + counter.
module fwd_scoreboard_port #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int SW    = 2
) (
    input  logic [DEPTH-1:0]          v_i,
    input  logic [DEPTH-1:0][AW-1:0]  wsel_i,
    input  logic [DEPTH-1:0]          rdy_i,
    input  logic [AW-1:0]             rsel_i,
    input  logic                      ruse_i,
    output logic [SW-1:0]             sel_o,
    output logic                      haz_o
);
    // Scan oldest to youngest so the youngest matching producer is written last.
    always_comb begin
        sel_o = '0;
        haz_o = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ruse_i && (rsel_i != '0) && v_i[k] && (wsel_i[k] == rsel_i)) begin
                sel_o = SW'(k + 1);
                haz_o = !rdy_i[k];
            end
        end
    end
endmodule

module fwd_scoreboard #(
    parameter int DEPTH = 2,
    parameter int NRD   = 2,
    parameter int AW    = 5,
    parameter int CNTW  = 32
) (
    input  logic            CLK,
    input  logic            RST,
    fwd_scoreboard_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]          v_q, v_d;
    logic [DEPTH-1:0][AW-1:0]  wsel_q, wsel_d;
    logic [DEPTH-1:0]          load_q, load_d;
    logic [DEPTH-1:0]          rdy_q, rdy_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;
    logic [NRD-1:0]            haz;

    for (genvar p = 0; p < NRD; p++) begin : g_port
        fwd_scoreboard_port #(.DEPTH(DEPTH), .AW(AW), .SW(SW)) u_port (
            .v_i    (v_q),
            .wsel_i (wsel_q),
            .rdy_i  (rdy_q),
            .rsel_i (bus.rsel[p]),
            .ruse_i (bus.ruse[p]),
            .sel_o  (bus.fwd_sel[p]),
            .haz_o  (haz[p])
        );
    end

    assign bus.stall       = |haz;
    assign bus.stall_count = cnt_q;

    always_comb begin
        v_d    = v_q;
        wsel_d = wsel_q;
        load_d = load_q;
        rdy_d  = rdy_q;
        if (bus.advance) begin
            // Anything past MEM has its data, loads included.
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k]    = v_q[k-1];
                wsel_d[k] = wsel_q[k-1];
                load_d[k] = load_q[k-1];
                rdy_d[k]  = 1'b1;
            end
            // A stalled consumer stays in EX, so a bubble goes down the pipe.
            v_d[0]    = bus.ex_wen && (bus.ex_wsel != '0) && !bus.flush && !bus.stall;
            wsel_d[0] = bus.ex_wsel;
            load_d[0] = bus.ex_load;
            rdy_d[0]  = !bus.ex_load;
        end else if (bus.mem_ready && load_q[0]) begin
            rdy_d[0] = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.stall && (cnt_q != {CNTW{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v_q    <= '0;
            wsel_q <= '0;
            load_q <= '0;
            rdy_q  <= '0;
            cnt_q  <= '0;
        end else begin
            v_q    <= v_d;
            wsel_q <= wsel_d;
            load_q <= load_d;
            rdy_q  <= rdy_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Randomised + directed bench for fwd_scoreboard; three instances (default,
// CNTW=4, DEPTH=1) share one stimulus stream, checked against a producer-list model.
module tb_fwd_scoreboard;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    fwd_scoreboard_if #(.DEPTH(2), .NRD(2), .AW(5), .CNTW(32)) bus_a ();
    fwd_scoreboard_if #(.DEPTH(2), .NRD(2), .AW(5), .CNTW(4))  bus_b ();
    fwd_scoreboard_if #(.DEPTH(1), .NRD(2), .AW(5), .CNTW(32)) bus_c ();

    fwd_scoreboard #(.DEPTH(2), .NRD(2), .AW(5), .CNTW(32)) u_a (.CLK(CLK), .RST(RST), .bus(bus_a.slave));
    fwd_scoreboard #(.DEPTH(2), .NRD(2), .AW(5), .CNTW(4))  u_b (.CLK(CLK), .RST(RST), .bus(bus_b.slave));
    fwd_scoreboard #(.DEPTH(1), .NRD(2), .AW(5), .CNTW(32)) u_c (.CLK(CLK), .RST(RST), .bus(bus_c.slave));

    assign bus_b.advance   = bus_a.advance;
    assign bus_b.flush     = bus_a.flush;
    assign bus_b.ex_wen    = bus_a.ex_wen;
    assign bus_b.ex_wsel   = bus_a.ex_wsel;
    assign bus_b.ex_load   = bus_a.ex_load;
    assign bus_b.rsel      = bus_a.rsel;
    assign bus_b.ruse      = bus_a.ruse;
    assign bus_b.mem_ready = bus_a.mem_ready;
    assign bus_c.advance   = bus_a.advance;
    assign bus_c.flush     = bus_a.flush;
    assign bus_c.ex_wen    = bus_a.ex_wen;
    assign bus_c.ex_wsel   = bus_a.ex_wsel;
    assign bus_c.ex_load   = bus_a.ex_load;
    assign bus_c.rsel      = bus_a.rsel;
    assign bus_c.ruse      = bus_a.ruse;
    assign bus_c.mem_ready = bus_a.mem_ready;

    typedef struct packed {
        logic [2:0][1:0][1:0] fs;
        logic [2:0]           st;
        logic [2:0][31:0]     cnt;
    } exp_t;

    typedef struct {
        bit       v;
        bit [4:0] w;
        bit       ld;
        bit       rdy;
    } prod_t;

    exp_t  expq[$];
    int    checks = 0;
    int    errors = 0;

    // Reference: per instance, list of producers past EX, youngest first.
    prod_t  m [3][2];
    int     dep  [3] = '{2, 2, 1};
    longint cmax [3] = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};
    longint cnt  [3];
    bit     pst  [3];
    bit     known = 1'b0;

    bit       c_rst, c_adv, c_fl, c_wen, c_ld, c_mr;
    bit [4:0] c_ws;
    bit [1:0][4:0] c_rs;
    bit [1:0] c_ru;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t got %0h expected %0h", nm, idx, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (c_rst) begin
                for (int k = 0; k < 2; k++) m[i][k] = '{1'b0, 5'd0, 1'b0, 1'b0};
                cnt[i] = 0;
            end else begin
                if (pst[i] && cnt[i] < cmax[i]) cnt[i] = cnt[i] + 1;
                if (c_adv) begin
                    if (dep[i] == 2) begin
                        m[i][1]     = m[i][0];
                        m[i][1].rdy = 1'b1;
                    end
                    m[i][0].v   = c_wen && (c_ws != 0) && !c_fl && !pst[i];
                    m[i][0].w   = c_ws;
                    m[i][0].ld  = c_ld;
                    m[i][0].rdy = !c_ld;
                end else if (c_mr && m[i][0].ld) begin
                    m[i][0].rdy = 1'b1;
                end
            end
        end
        if (c_rst) known = 1'b1;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            bit st;
            st = 1'b0;
            for (int p = 0; p < 2; p++) begin
                int sel;
                sel = 0;
                for (int k = 0; k < dep[i]; k++)
                    if (sel == 0 && c_ru[p] && c_rs[p] != 0 && m[i][k].v && m[i][k].w == c_rs[p])
                        sel = k + 1;
                e.fs[i][p] = 2'(sel);
                if (sel != 0 && !m[i][sel-1].rdy) st = 1'b1;
            end
            e.st[i]  = st;
            e.cnt[i] = 32'(cnt[i]);
        end
        return e;
    endfunction

    task automatic step(input bit rst, input bit adv, input bit fl, input bit wen, input bit [4:0] ws,
                        input bit ld, input bit [4:0] r0, input bit [4:0] r1, input bit [1:0] ru, input bit mr);
        exp_t e;
        @(posedge CLK);
        #1;
        model_edge();
        c_rst = rst; c_adv = adv; c_fl = fl; c_wen = wen; c_ws = ws; c_ld = ld;
        c_rs[0] = r0; c_rs[1] = r1; c_ru = ru; c_mr = mr;
        RST             = rst;
        bus_a.advance   = adv;
        bus_a.flush     = fl;
        bus_a.ex_wen    = wen;
        bus_a.ex_wsel   = ws;
        bus_a.ex_load   = ld;
        bus_a.rsel[0]   = r0;
        bus_a.rsel[1]   = r1;
        bus_a.ruse      = ru;
        bus_a.mem_ready = mr;
        e = model_out();
        for (int i = 0; i < 3; i++) pst[i] = e.st[i];
        if (known) expq.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            for (int p = 0; p < 2; p++) begin
                chk("fwd_sel_a", p, {30'd0, bus_a.fwd_sel[p]}, {30'd0, e.fs[0][p]});
                chk("fwd_sel_b", p, {30'd0, bus_b.fwd_sel[p]}, {30'd0, e.fs[1][p]});
                chk("fwd_sel_c", p, {31'd0, bus_c.fwd_sel[p]}, {30'd0, e.fs[2][p]});
            end
            chk("stall_a", 0, {31'd0, bus_a.stall}, {31'd0, e.st[0]});
            chk("stall_b", 0, {31'd0, bus_b.stall}, {31'd0, e.st[1]});
            chk("stall_c", 0, {31'd0, bus_c.stall}, {31'd0, e.st[2]});
            chk("count_a", 0, bus_a.stall_count, e.cnt[0]);
            chk("count_b", 0, {28'd0, bus_b.stall_count}, e.cnt[1]);
            chk("count_c", 0, bus_c.stall_count, e.cnt[2]);
        end
    end

    initial begin
        // Reset with live pipeline activity, then read r5 after release.
        step(1, 1, 0, 1, 5, 0, 5, 5, 2'b11, 0);
        step(1, 1, 0, 1, 5, 0, 5, 5, 2'b11, 1);
        step(0, 0, 0, 0, 0, 0, 5, 0, 2'b01, 0);
        // ALU back-to-back, then one bubble.
        step(0, 1, 0, 1, 3, 0, 0, 0, 2'b00, 0);
        step(0, 1, 0, 0, 0, 0, 3, 0, 2'b01, 0);
        step(0, 0, 0, 0, 0, 0, 3, 0, 2'b01, 0);
        // Youngest wins; r0 never forwards.
        step(0, 1, 0, 1, 4, 0, 0, 0, 2'b00, 0);
        step(0, 1, 0, 1, 4, 0, 0, 0, 2'b00, 0);
        step(0, 0, 0, 0, 0, 0, 0, 4, 2'b10, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);
        // Load-use with a 3-cycle miss, then data, then bubble.
        step(0, 1, 0, 1, 7, 1, 0, 0, 2'b00, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 7, 0, 2'b01, 0);
        step(0, 0, 0, 0, 0, 0, 7, 0, 2'b01, 1);
        step(0, 0, 0, 0, 0, 0, 7, 0, 2'b01, 0);
        step(0, 1, 0, 0, 0, 0, 7, 0, 2'b01, 0);
        step(0, 0, 0, 0, 0, 0, 7, 7, 2'b11, 0);
        // Flush kills the incoming producer; flush without advance is ignored.
        step(0, 1, 1, 1, 9, 0, 0, 0, 2'b00, 0);
        step(0, 0, 1, 1, 10, 0, 9, 9, 2'b11, 0);
        // advance + mem_ready with the load in entry 0.
        step(0, 1, 0, 1, 11, 1, 0, 0, 2'b00, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 1);
        step(0, 0, 0, 0, 0, 0, 11, 0, 2'b01, 0);
        // Long stall to saturate the 4-bit counter.
        step(0, 1, 0, 1, 12, 1, 0, 0, 2'b00, 0);
        repeat (20) step(0, 0, 0, 0, 0, 0, 12, 0, 2'b01, 0);
        step(0, 0, 0, 0, 0, 0, 12, 0, 2'b01, 1);
        // Reset in the middle of a pending load.
        step(0, 1, 0, 1, 13, 1, 0, 0, 2'b00, 0);
        step(1, 0, 0, 0, 0, 0, 13, 0, 2'b01, 0);
        step(0, 0, 0, 0, 0, 0, 13, 13, 2'b11, 0);
        // Random traffic over a small register range to force frequent matches.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0));
        end
        @(posedge CLK);
        @(negedge CLK);
        #1;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
